// File: rtl/label_ext_pipe.sv
// label_ext_pipe: two-stage label extender and branch-target adder with valid/ready handshake
module label_ext_pipe #(
  parameter int XLEN  = 32,
  parameter int LW    = 26,
  parameter int SW    = 16,
  parameter int SHIFT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [LW-1:0]   label,
  input  logic [1:0]      mode,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] ext,
  output logic [XLEN-1:0] target,
  output logic            ovf
);
  if (XLEN < LW || SW > LW || SW < 1 || SHIFT < 0 || SHIFT > 3) begin : g_bad
    $fatal(1, "label_ext_pipe: illegal parameter set");
  end
  logic            s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [XLEN-1:0] s1_ext_q, s1_ext_d, s1_pc_q, s1_pc_d;
  logic [XLEN-1:0] s2_ext_q, s2_ext_d, s2_tgt_q, s2_tgt_d;
  logic            s2_ovf_q, s2_ovf_d;
  logic            s2_adv, in_xfer, s1_move;
  logic [XLEN-1:0] ext_c, sh, sum;
  always_comb begin
    s2_adv   = out_ready || !s2_v_q;
    in_ready = !s1_v_q || s2_adv;
    in_xfer  = in_valid && in_ready;
    s1_move  = s1_v_q && s2_adv;
    ext_c    = mode == 2'b00 ? XLEN'($signed(label)) :
               mode == 2'b01 ? XLEN'($signed(label[SW-1:0])) :
               mode == 2'b10 ? XLEN'(label[SW-1:0]) : XLEN'(label);
    sh       = s1_ext_q << SHIFT;
    sum      = s1_pc_q + sh;
    s1_v_d   = in_xfer ? 1'b1 : (s2_adv ? 1'b0 : s1_v_q);
    s2_v_d   = s2_adv ? s1_v_q : s2_v_q;
    s1_ext_d = in_xfer ? ext_c : s1_ext_q;
    s1_pc_d  = in_xfer ? pc : s1_pc_q;
    s2_ext_d = s1_move ? s1_ext_q : s2_ext_q;
    s2_tgt_d = s1_move ? sum : s2_tgt_q;
    s2_ovf_d = s1_move ? (s1_pc_q[XLEN-1] == sh[XLEN-1]) && (sum[XLEN-1] != sh[XLEN-1]) : s2_ovf_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      s1_ext_q <= '0;
      s1_pc_q  <= '0;
      s2_ext_q <= '0;
      s2_tgt_q <= '0;
      s2_ovf_q <= 1'b0;
    end else begin
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      s1_ext_q <= s1_ext_d;
      s1_pc_q  <= s1_pc_d;
      s2_ext_q <= s2_ext_d;
      s2_tgt_q <= s2_tgt_d;
      s2_ovf_q <= s2_ovf_d;
    end
  end
  assign out_valid = s2_v_q;
  assign ext       = s2_ext_q;
  assign target    = s2_tgt_q;
  assign ovf       = s2_ovf_q;
endmodule

// File: tb/tb_label_ext_pipe.sv
// tb_label_ext_pipe: directed checks of extension modes, target/overflow, stalls, throughput and reset
module tb_label_ext_pipe;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, ovf;
  logic [25:0] label = '0;
  logic [1:0]  mode = '0;
  logic [31:0] pc = '0, ext, target;
  int checks = 0, errors = 0;
  label_ext_pipe #(.XLEN(32), .LW(26), .SW(16), .SHIFT(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .label(label), .mode(mode),
    .pc(pc), .out_valid(out_valid), .out_ready(out_ready), .ext(ext), .target(target), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp_v);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [25:0] l, input logic [1:0] m, input logic [31:0] p);
    in_valid = 1'b1;
    label = l;
    mode = m;
    pc = p;
  endtask
  task automatic send_one(input string tag, input logic [25:0] l, input logic [1:0] m,
                          input logic [31:0] p, input logic [31:0] e_ext, input logic [31:0] e_tgt,
                          input logic e_ovf);
    out_ready = 1'b1;
    drive(l, m, p);
    tick();
    in_valid = 1'b0;
    tick();
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_ext"}, ext, e_ext);
    chk({tag, "_target"}, target, e_tgt);
    chk({tag, "_ovf"}, {31'b0, ovf}, {31'b0, e_ovf});
  endtask
  initial begin
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ext", ext, 32'd0);
    chk("rst_target", target, 32'd0);
    chk("rst_ovf", {31'b0, ovf}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    send_one("m00_neg", 26'h2000004, 2'b00, 32'h0, 32'hFE000004, 32'hF8000010, 1'b0);
    send_one("m00_pos", 26'h1555545, 2'b00, 32'h0, 32'h01555545, 32'h05555514, 1'b0);
    send_one("m01_pos", 26'h1555545, 2'b01, 32'h0, 32'h00005545, 32'h00015514, 1'b0);
    send_one("m01_neg", 26'h0008000, 2'b01, 32'h0, 32'hFFFF8000, 32'hFFFE0000, 1'b0);
    send_one("m10", 26'h0008000, 2'b10, 32'h0, 32'h00008000, 32'h00020000, 1'b0);
    send_one("m11", 26'h3FFFFFF, 2'b11, 32'h0, 32'h03FFFFFF, 32'h0FFFFFFC, 1'b0);
    send_one("minus1", 26'h3FFFFFF, 2'b00, 32'h100, 32'hFFFFFFFF, 32'h000000FC, 1'b0);
    send_one("ovf_pos", 26'h0000001, 2'b00, 32'h7FFFFFFC, 32'h00000001, 32'h80000000, 1'b1);
    send_one("ovf_neg", 26'h2000000, 2'b00, 32'h80000000, 32'hFE000000, 32'h78000000, 1'b1);
    tick();
    chk("idle_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(26'd1, 2'b00, 32'h0);
    tick();
    drive(26'd2, 2'b00, 32'h0);
    tick();
    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
    drive(26'd3, 2'b00, 32'h0);
    tick();
    chk("stall_in_ready2", {31'b0, in_ready}, 32'd0);
    chk("stall_valid", {31'b0, out_valid}, 32'd1);
    chk("stall_ext", ext, 32'd1);
    tick();
    chk("stall_ext_hold", ext, 32'd1);
    chk("stall_target_hold", target, 32'd4);
    out_ready = 1'b1;
    #1;
    chk("resume_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("drain_b_valid", {31'b0, out_valid}, 32'd1);
    chk("drain_b_ext", ext, 32'd2);
    tick();
    chk("drain_c_valid", {31'b0, out_valid}, 32'd1);
    chk("drain_c_ext", ext, 32'd3);
    tick();
    chk("drain_empty", {31'b0, out_valid}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      drive(26'(i + 10), 2'b11, 32'h1000);
      #1;
      chk("tp_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      if (i > 0) begin
        chk("tp_valid", {31'b0, out_valid}, 32'd1);
        chk("tp_ext", ext, 32'(i + 9));
        chk("tp_target", target, 32'h1000 + 32'((i + 9) * 4));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("tp_last_valid", {31'b0, out_valid}, 32'd1);
    chk("tp_last_ext", ext, 32'd17);
    tick();
    chk("tp_done", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b0;
    drive(26'h0000055, 2'b00, 32'h40);
    tick();
    drive(26'h0000066, 2'b00, 32'h40);
    tick();
    in_valid = 1'b0;
    chk("full_valid", {31'b0, out_valid}, 32'd1);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_ext", ext, 32'd0);
    chk("mid_rst_target", target, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("post_rst_empty", {31'b0, out_valid}, 32'd0);
    send_one("post_rst", 26'h0000007, 2'b00, 32'h10, 32'h00000007, 32'h0000002C, 1'b0);
    tick();
    chk("post_rst_nodup", {31'b0, out_valid}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/label_ext_pipe.md
# label_ext_pipe

Parametrised, two-stage pipelined label/immediate extender and branch-target generator for the KGP-miniRISC datapath. It accepts a raw label field plus the current PC under a valid/ready handshake and extends the label per a runtime mode (long/short, signed/unsigned). It then scales the label by a word shift, adds it to the PC, and delivers both the extended value and the branch target. It sits between decode and the PC-update/ALU-operand muxes and replaces the fixed combinational 26-bit and 16-bit sign-extension.

## Interface
- XLEN, 32: datapath width; must satisfy XLEN >= LW.
- LW, 26: long-label width; the label input is LW bits.
- SW, 16: short-label width; must satisfy SW <= LW. The short label is label[SW-1:0].
- SHIFT, 0: left shift applied to the extended value before the PC add (2 = word-addressed branches). Legal range is 0 to 3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream holds a valid request.
- in_ready  out  1  block accepts the request this cycle.
- label  in  LW  raw label field.
- mode  in  2  00 long signed, 01 short signed, 10 short zero-extend, 11 long zero-extend.
- pc  in  XLEN  base address for the target.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- ext  out  XLEN  extended label, unshifted.
- target  out  XLEN  pc + (ext << SHIFT), mod 2^XLEN.
- ovf  out  1  signed overflow of the target add.

## Operation
- Stage 1 (S1) registers the extended label, computed as follows:
  - Mode 00: replicate label[LW-1] into the upper bits.
  - Mode 01: replicate label[SW-1].
  - Mode 10: zero-fill above bit SW-1.
  - Mode 11: zero-fill above bit LW-1.
- S1 also registers pc.
- Stage 2 (S2) registers:
  - ext from S1, passed through unchanged.
  - target = pc + (ext << SHIFT); bits shifted out above XLEN-1 are discarded.
  - ovf = 1 when pc[XLEN-1] == sh[XLEN-1] and target[XLEN-1] differs from them, where sh is the shifted value.
- Each stage has a valid flag (s1_v, s2_v). A stage loads when it is empty or its contents are leaving in the same cycle.
  - s2 advances when out_ready is high, or when s2_v is 0.
  - in_ready = !s1_v || s2 advances. This is combinational; there is no combinational path from in_valid to in_ready.
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- While out_valid && !out_ready, ext, target and ovf hold stable. Upstream stalls once S1 is also full.
- Data registers load only on a transfer into their stage. Valid flags clear when a stage empties.
- Simultaneous in-transfer and out-transfer with both stages full: S2 takes S1's contents, S1 takes the new input. Throughput is 1 per cycle, with no bubble.
- Parameter legality is checked at elaboration; an illegal set is a fatal error.

## Timing
- Reset, asynchronous and effective immediately:
  - s1_v, s2_v, out_valid = 0.
  - ext, target, ovf and all internal data registers = 0.
  - in_ready = 1 once rst is low.
- Latency: an input transferred at edge N gives out_valid = 1 after edge N+1, provided no stall. Results appear in order.
- Capacity is 2 entries. With out_ready held low, exactly 2 inputs are accepted; in_ready is 0 from the cycle after the second acceptance.
- Reset asserted mid-operation discards both stages immediately. No partial result is emitted after release.
- out_valid never depends combinationally on in_valid.

## Test plan
- Reset, then mode 00 with label 26'h2000004, pc 0, SHIFT 2 -> two edges later ext 0xFE000004, target 0xF8000010, ovf 0.
- Mode 00 with label 26'b01010101010101010101000101 -> ext 0x01555545. The same label in mode 01 -> ext 0x00005545. Mode 01 with label[15:0] = 0x8000 -> 0xFFFF8000. Mode 10 with the same label -> 0x00008000.
- SHIFT 2, mode 00, label 26'h3FFFFFF (-1), pc 0x00000100 -> target 0x000000FC, ovf 0. pc 0x7FFFFFFC with label +1 -> target 0x80000000, ovf 1.
- out_ready low, stream 3 requests -> first two accepted, in_ready drops and out_valid/ext stay stable. Raise out_ready -> all 3 results arrive in order, one per cycle, with no duplicates.
- Back-to-back stream of 8 requests with out_ready held high -> 8 results on 8 consecutive cycles after the first latency. in_ready stays 1 throughout.
- Assert rst with both stages full -> out_valid 0 and outputs 0 immediately. After release the first new input emerges after 2 edges, with no stale data.
